// File: rtl/psum_mem_pkg.sv
// Shared types for the partial-sum SRAM scheduler: grant kinds and posted-write entries.
package psum_mem_pkg;

    localparam int unsigned PSUM_ADDR_W = 17;
    localparam int unsigned PSUM_DATA_W = 32;

    typedef enum logic [2:0] {
        GNT_NONE,
        GNT_RD,
        GNT_FWD,
        GNT_DRAIN,
        GNT_HOST
    } mem_gnt_t;

    typedef struct packed {
        logic [PSUM_ADDR_W-1:0] addr;
        logic [PSUM_DATA_W-1:0] data;
    } wbuf_entry_t;

endpackage

// File: rtl/psum_wbuf.sv
// Posted-write FIFO with a parallel address compare that returns the youngest
// matching entry's data for read forwarding.
module psum_wbuf
    import psum_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  wbuf_entry_t                  push_entry_i,
    input  logic                         pop_i,
    input  logic [PSUM_ADDR_W-1:0]       lookup_addr_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output wbuf_entry_t                  head_o,
    output logic                         hit_o,
    output logic [PSUM_DATA_W-1:0]       hit_data_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    wbuf_entry_t      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers alone.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= push_entry_i;
    end

    // Walk oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        hit_o      = 1'b0;
        hit_data_o = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (CNT_W'(k) < count_q &&
                mem_q[PTR_W'(rd_ptr_q + PTR_W'(k))].addr == lookup_addr_i) begin
                hit_o      = 1'b1;
                hit_data_o = mem_q[PTR_W'(rd_ptr_q + PTR_W'(k))].data;
            end
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/psum_mem_scheduler.sv
// Single-port psum SRAM arbiter: controller reads/writes, host access, posted
// writes with read forwarding and one SRAM operation per cycle.
module psum_mem_scheduler
    import psum_mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = PSUM_ADDR_W,
    parameter int unsigned DATA_W     = PSUM_DATA_W,
    parameter int unsigned WBUF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              arst_in,
    input  logic              rd_req,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_req,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              sram_ce,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              idle
);

    localparam int unsigned CNT_W = $clog2(WBUF_DEPTH + 1);

    mem_gnt_t          gnt;
    logic              push, pop, hit, full, empty;
    logic [CNT_W-1:0]  count;
    wbuf_entry_t       push_entry, head;
    logic [PSUM_DATA_W-1:0] hit_data;

    logic              rd_valid_q, rd_valid_d;
    logic              rd_sram_q, rd_sram_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              host_rvalid_q, host_rvalid_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;

    assign full       = (count == CNT_W'(WBUF_DEPTH));
    assign empty      = (count == '0);
    assign wr_ready   = !full;
    assign push       = wr_req && wr_ready;
    assign push_entry = '{addr: PSUM_ADDR_W'(wr_addr), data: PSUM_DATA_W'(wr_data)};

    psum_wbuf #(
        .DEPTH(WBUF_DEPTH)
    ) u_wbuf (
        .clk_i        (clk),
        .rst_i        (arst_in),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .lookup_addr_i(PSUM_ADDR_W'(rd_addr)),
        .count_o      (count),
        .head_o       (head),
        .hit_o        (hit),
        .hit_data_o   (hit_data)
    );

    // Grant priority: full drain, controller read, drain, host.
    always_comb begin
        gnt = GNT_NONE;
        if (arst_in)       gnt = GNT_NONE;
        else if (full)     gnt = GNT_DRAIN;
        else if (rd_req)   gnt = hit ? GNT_FWD : GNT_RD;
        else if (!empty)   gnt = GNT_DRAIN;
        else if (host_req) gnt = GNT_HOST;
    end

    // A forwarded read leaves the SRAM port free, so the drain rides along.
    always_comb begin
        rd_ready   = 1'b0;
        host_gnt   = 1'b0;
        pop        = 1'b0;
        sram_ce    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        case (gnt)
            GNT_RD: begin
                rd_ready  = 1'b1;
                sram_ce   = 1'b1;
                sram_addr = rd_addr;
            end
            GNT_FWD, GNT_DRAIN: begin
                rd_ready   = (gnt == GNT_FWD);
                pop        = 1'b1;
                sram_ce    = 1'b1;
                sram_we    = 1'b1;
                sram_addr  = ADDR_W'(head.addr);
                sram_wdata = DATA_W'(head.data);
            end
            GNT_HOST: begin
                host_gnt   = 1'b1;
                sram_ce    = 1'b1;
                sram_we    = host_we;
                sram_addr  = host_addr;
                sram_wdata = host_wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        rd_valid_d    = (gnt == GNT_RD) || (gnt == GNT_FWD);
        rd_sram_d     = (gnt == GNT_RD);
        host_rvalid_d = (gnt == GNT_HOST) && !host_we;
        rd_data_d     = rd_data_q;
        host_rdata_d  = host_rdata_q;
        if (gnt == GNT_FWD)             rd_data_d = DATA_W'(hit_data);
        else if (rd_valid_q && rd_sram_q) rd_data_d = sram_rdata;
        if (host_rvalid_q)              host_rdata_d = sram_rdata;
    end

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            rd_valid_q    <= 1'b0;
            rd_sram_q     <= 1'b0;
            rd_data_q     <= '0;
            host_rvalid_q <= 1'b0;
            host_rdata_q  <= '0;
        end else begin
            rd_valid_q    <= rd_valid_d;
            rd_sram_q     <= rd_sram_d;
            rd_data_q     <= rd_data_d;
            host_rvalid_q <= host_rvalid_d;
            host_rdata_q  <= host_rdata_d;
        end
    end

    // SRAM data arrives the cycle after the read; capture it so it holds afterwards.
    assign rd_valid    = rd_valid_q;
    assign rd_data     = (rd_valid_q && rd_sram_q) ? sram_rdata : rd_data_q;
    assign host_rvalid = host_rvalid_q;
    assign host_rdata  = host_rvalid_q ? sram_rdata : host_rdata_q;
    assign idle        = empty && !rd_valid_q && !host_rvalid_q;

endmodule

// File: tb/tb_psum_mem_scheduler.sv
// Bench for psum_mem_scheduler: handshake vector table, read-data scoreboard
// against an architectural memory model, and host/reset sequences.
module tb_psum_mem_scheduler;

    localparam int unsigned ADDR_W = 17;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 4;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] word_t;

    logic  clk = 1'b0;
    logic  arst_in;
    logic  rd_req, rd_ready, rd_valid;
    addr_t rd_addr;
    word_t rd_data;
    logic  wr_req, wr_ready;
    addr_t wr_addr;
    word_t wr_data;
    logic  host_req, host_we, host_gnt, host_rvalid;
    addr_t host_addr;
    word_t host_wdata, host_rdata;
    logic  sram_ce, sram_we;
    addr_t sram_addr;
    word_t sram_wdata, sram_rdata;
    logic  idle;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    psum_mem_scheduler #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WBUF_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .arst_in(arst_in),
        .rd_req(rd_req), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_req(wr_req), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
        .host_rdata(host_rdata),
        .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .idle(idle)
    );

    // Single-port SRAM with 1-cycle read latency.
    word_t sram_mem [addr_t];
    word_t ref_mem  [addr_t];

    function automatic word_t mem_get(input addr_t a, input logic use_ref);
        if (use_ref) return ref_mem.exists(a) ? ref_mem[a] : '0;
        return sram_mem.exists(a) ? sram_mem[a] : '0;
    endfunction

    always @(posedge clk) begin
        if (sram_ce) begin
            if (sram_we) sram_mem[sram_addr] = sram_wdata;
            else         sram_rdata <= mem_get(sram_addr, 1'b0);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: expected data queued at fire, compared when valid appears.
    word_t rd_q[$];
    word_t host_q[$];

    always @(negedge clk) begin
        if (arst_in) begin
            rd_q.delete();
            host_q.delete();
        end else begin
            if (rd_valid || rd_q.size() != 0) begin
                check("rd_valid", 64'(rd_valid), 64'(rd_q.size() != 0));
                if (rd_valid && rd_q.size() != 0) check("rd_data", 64'(rd_data), 64'(rd_q.pop_front()));
                else rd_q.delete();
            end
            if (host_rvalid || host_q.size() != 0) begin
                check("host_rvalid", 64'(host_rvalid), 64'(host_q.size() != 0));
                if (host_rvalid && host_q.size() != 0) check("host_rdata", 64'(host_rdata), 64'(host_q.pop_front()));
                else host_q.delete();
            end
            if (rd_req && rd_ready) rd_q.push_back(mem_get(rd_addr, 1'b1));
            if (wr_req && wr_ready) ref_mem[wr_addr] = wr_data;
            if (host_gnt) begin
                if (host_we) ref_mem[host_addr] = host_wdata;
                else         host_q.push_back(mem_get(host_addr, 1'b1));
            end
        end
    end

    typedef struct {
        logic  rd;
        addr_t ra;
        logic  wr;
        addr_t wa;
        word_t wd;
        logic  e_rr, e_wrdy, e_ce, e_we;
    } vec_t;

    vec_t tbl [17];

    task automatic drive(input logic rd, input addr_t ra, input logic wr, input addr_t wa,
                         input word_t wd, input logic hr, input logic hwe, input addr_t ha,
                         input word_t hwd);
        @(posedge clk);
        #1;
        rd_req = rd;  rd_addr = ra;
        wr_req = wr;  wr_addr = wa;  wr_data = wd;
        host_req = hr; host_we = hwe; host_addr = ha; host_wdata = hwd;
    endtask

    task automatic drive_idle();
        drive(0, '0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        drive_idle();
        @(negedge clk);
        while (!idle && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(idle), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int waited;
        int we_seen;
        arst_in = 1'b1;
        rd_req = 0; rd_addr = '0; wr_req = 0; wr_addr = '0; wr_data = '0;
        host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
        sram_mem[17'h10] = 32'h55; sram_mem[17'h20] = 32'h77;
        sram_mem[17'h30] = 32'h33; sram_mem[17'h45] = 32'h99;
        ref_mem = sram_mem;

        // rd, addr, wr, addr, data, then expected rd_ready, wr_ready, sram_ce, sram_we
        tbl[0]  = '{1, 17'h10, 0, 17'h00, 32'h000, 1, 1, 1, 0};
        tbl[1]  = '{0, 17'h00, 1, 17'h10, 32'h0AA, 0, 1, 0, 0};
        tbl[2]  = '{1, 17'h10, 0, 17'h00, 32'h000, 1, 1, 1, 1};
        tbl[3]  = '{1, 17'h20, 1, 17'h10, 32'h001, 1, 1, 1, 0};
        tbl[4]  = '{1, 17'h20, 1, 17'h10, 32'h002, 1, 1, 1, 0};
        tbl[5]  = '{1, 17'h10, 0, 17'h00, 32'h000, 1, 1, 1, 1};
        tbl[6]  = '{0, 17'h00, 0, 17'h00, 32'h000, 0, 1, 1, 1};
        tbl[7]  = '{1, 17'h30, 1, 17'h40, 32'h140, 1, 1, 1, 0};
        tbl[8]  = '{1, 17'h30, 1, 17'h41, 32'h141, 1, 1, 1, 0};
        tbl[9]  = '{1, 17'h30, 1, 17'h42, 32'h142, 1, 1, 1, 0};
        tbl[10] = '{1, 17'h30, 1, 17'h43, 32'h143, 1, 1, 1, 0};
        tbl[11] = '{1, 17'h30, 1, 17'h44, 32'h144, 0, 0, 1, 1};
        tbl[12] = '{1, 17'h30, 0, 17'h00, 32'h000, 1, 1, 1, 0};
        tbl[13] = '{0, 17'h00, 1, 17'h44, 32'h144, 0, 1, 1, 1};
        tbl[14] = '{1, 17'h45, 1, 17'h45, 32'h145, 1, 1, 1, 0};
        tbl[15] = '{1, 17'h45, 0, 17'h00, 32'h000, 0, 0, 1, 1};
        tbl[16] = '{1, 17'h45, 0, 17'h00, 32'h000, 1, 1, 1, 1};

        // Reset state
        @(negedge clk);
        check("rst_idle", 64'(idle), 64'(1));
        check("rst_rd_valid", 64'(rd_valid), 64'(0));
        check("rst_host_rvalid", 64'(host_rvalid), 64'(0));
        check("rst_sram_ce", 64'(sram_ce), 64'(0));
        check("rst_sram_we", 64'(sram_we), 64'(0));
        check("rst_rd_data", 64'(rd_data), 64'(0));
        check("rst_host_rdata", 64'(host_rdata), 64'(0));
        @(posedge clk);
        #1 arst_in = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].rd, tbl[i].ra, tbl[i].wr, tbl[i].wa, tbl[i].wd, 0, 0, '0, '0);
            @(negedge clk);
            check($sformatf("v%0d_rd_ready", i), 64'(rd_ready), 64'(tbl[i].e_rr));
            check($sformatf("v%0d_wr_ready", i), 64'(wr_ready), 64'(tbl[i].e_wrdy));
            check($sformatf("v%0d_sram_ce", i), 64'(sram_ce), 64'(tbl[i].e_ce));
            check($sformatf("v%0d_sram_we", i), 64'(sram_we), 64'(tbl[i].e_we));
            check($sformatf("v%0d_host_gnt", i), 64'(host_gnt), 64'(0));
        end
        wait_idle("drain_idle");
        check("sram_0x10_youngest", 64'(mem_get(17'h10, 1'b0)), 64'(32'h2));
        check("sram_0x44", 64'(mem_get(17'h44, 1'b0)), 64'(32'h144));
        check("sram_0x45", 64'(mem_get(17'h45, 1'b0)), 64'(32'h145));

        // Host read waits for two buffered writes to drain
        drive(1, 17'h30, 1, 17'h50, 32'h500, 0, 0, '0, '0);
        drive(1, 17'h30, 1, 17'h51, 32'h501, 0, 0, '0, '0);
        drive(0, '0, 0, '0, '0, 1, 0, 17'h51, '0);
        waited = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (host_gnt) break;
            waited++;
        end
        check("host_wait_cycles", 64'(waited), 64'(2));
        drive(0, '0, 0, '0, '0, 1, 1, 17'h60, 32'h600);
        @(negedge clk);
        check("host_wr_gnt", 64'(host_gnt), 64'(1));
        check("host_wr_sram_we", 64'(sram_we), 64'(1));
        drive(0, '0, 0, '0, '0, 1, 0, 17'h60, '0);
        @(negedge clk);
        check("host_rd_gnt", 64'(host_gnt), 64'(1));
        wait_idle("host_idle");
        check("sram_0x51", 64'(mem_get(17'h51, 1'b0)), 64'(32'h501));

        // Reset with three buffered writes and a read in flight
        drive(1, 17'h30, 1, 17'h70, 32'h700, 0, 0, '0, '0);
        drive(1, 17'h30, 1, 17'h71, 32'h701, 0, 0, '0, '0);
        drive(1, 17'h30, 1, 17'h72, 32'h702, 0, 0, '0, '0);
        @(negedge clk);
        check("pre_rst_busy", 64'(idle), 64'(0));
        drive_idle();
        arst_in = 1'b1;
        #1;
        check("arst_idle", 64'(idle), 64'(1));
        check("arst_rd_valid", 64'(rd_valid), 64'(0));
        @(posedge clk);
        #1 arst_in = 1'b0;
        we_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (sram_we) we_seen++;
        end
        check("post_rst_sram_we", 64'(we_seen), 64'(0));
        check("post_rst_rd_valid", 64'(rd_valid), 64'(0));
        check("sram_0x70_untouched", 64'(mem_get(17'h70, 1'b0)), 64'(0));
        check("sram_0x72_untouched", 64'(mem_get(17'h72, 1'b0)), 64'(0));
        ref_mem = sram_mem;
        drive(1, 17'h70, 0, '0, '0, 0, 0, '0, '0);
        drive(1, 17'h10, 0, '0, '0, 0, 0, '0, '0);
        wait_idle("final_idle");
        check("scoreboard_empty", 64'(rd_q.size() + host_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
